// File: rtl/sm_step_pkg.sv
// rtl/sm_step_pkg.sv - shared types, constants and helpers for the step-pulse generator
package sm_step_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Shortest period that still yields a low phase after a one-cycle pulse
  localparam int unsigned MIN_PERIOD = 2;

  // Pulse high time for a given period: period >> shift, never below one cycle
  function automatic int unsigned hi_cycles(input int unsigned period, input int unsigned shift);
    int unsigned h;
    h = period >> shift;
    if (h == 0) h = 1;
    return h;
  endfunction

endpackage

// File: rtl/sm_step_chan.sv
// rtl/sm_step_chan.sv - one step-pulse channel (shadow, active, FSM, counters); ramp via SM_RAMP_EN
module sm_step_chan
  import sm_step_pkg::*;
#(
  parameter int W          = 16,
  parameter int CW         = 24,
  parameter int DUTY_SHIFT = 2,
  parameter int RAMP_DEC   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [W-1:0]  cfg_period,
  input  logic [CW-1:0] cfg_steps,
  input  logic          cfg_dir,
  input  logic          start,
  input  logic          abort,
  output logic          step,
  output logic          dir,
  output logic          busy,
  output logic          done
);

  state_t        state, state_d;
  logic [W-1:0]  shadow_period;
  logic [CW-1:0] shadow_steps;
  logic          shadow_dir;
  logic [W-1:0]  period_act, period_act_d;
  logic [W-1:0]  cnt, cnt_d;
  logic [CW-1:0] steps_left, steps_left_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;
  logic [W-1:0]  eff_period, eff_target;
  logic [CW-1:0] eff_steps;
  logic          eff_dir;
  logic [W-1:0]  start_period, wrap_period;
  logic [W-1:0]  hi;
  logic          wrap;

  // A write landing in the same cycle as start/wrap is seen immediately (bypass)
  always_comb begin
    eff_period = wr ? cfg_period : shadow_period;
    eff_steps  = wr ? cfg_steps  : shadow_steps;
    eff_dir    = wr ? cfg_dir    : shadow_dir;
    eff_target = (eff_period < W'(MIN_PERIOD)) ? W'(MIN_PERIOD) : eff_period;
  end

`ifdef SM_RAMP_EN
  logic [W:0] dbl_target;
  logic [W:0] dec_floor;

  // Ramp: start at twice the target, then shorten by RAMP_DEC per step until it is reached
  always_comb begin
    dbl_target   = {eff_target, 1'b0};
    start_period = dbl_target[W] ? {W{1'b1}} : dbl_target[W-1:0];
    dec_floor    = {1'b0, eff_target} + (W+1)'(RAMP_DEC);
    wrap_period  = ({1'b0, period_act} >= dec_floor) ? (period_act - W'(RAMP_DEC)) : eff_target;
  end
`else
  assign start_period = eff_target;
  assign wrap_period  = eff_target;
`endif

  assign hi   = W'(hi_cycles(32'(period_act), 32'(DUTY_SHIFT)));
  assign wrap = (cnt == (period_act - W'(1)));

  // Next-state and datapath updates; period changes only take effect at a wrap
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    steps_left_d = steps_left;
    period_act_d = period_act;
    dir_d        = dir_q;
    done_d       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (eff_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = RUN;
            cnt_d        = '0;
            steps_left_d = eff_steps;
            dir_d        = eff_dir;
            period_act_d = start_period;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          cnt_d        = '0;
          steps_left_d = steps_left - CW'(1);
          if (steps_left == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            period_act_d = wrap_period;
          end
        end else begin
          cnt_d = cnt + W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shadow and active register bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shadow_period <= '0;
      shadow_steps  <= '0;
      shadow_dir    <= 1'b0;
      period_act    <= W'(MIN_PERIOD);
      cnt           <= '0;
      steps_left    <= '0;
      dir_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state      <= state_d;
      period_act <= period_act_d;
      cnt        <= cnt_d;
      steps_left <= steps_left_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      if (wr) begin
        shadow_period <= cfg_period;
        shadow_steps  <= cfg_steps;
        shadow_dir    <= cfg_dir;
      end
    end
  end

  assign busy = (state == RUN);
  assign step = busy && (cnt < hi);
  assign dir  = dir_q;
  assign done = done_q;

endmodule

// File: rtl/sm_step_gen.sv
// rtl/sm_step_gen.sv - multi-channel step-pulse generator top, cfg decode only; ramp via SM_RAMP_EN
module sm_step_gen
  import sm_step_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int W          = 16,
  parameter int CW         = 24,
  parameter int DUTY_SHIFT = 2,
  parameter int RAMP_DEC   = 4,
  localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_period,
  input  logic [CW-1:0]  cfg_steps,
  input  logic           cfg_dir,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] abort,
  output logic [NCH-1:0] step,
  output logic [NCH-1:0] dir,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done
);

  logic [NCH-1:0] wr;

  // Channel select; cfg_ch values with no matching channel write nothing
  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = cfg_wr && (cfg_ch == CHW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    sm_step_chan #(
      .W          (W),
      .CW         (CW),
      .DUTY_SHIFT (DUTY_SHIFT),
      .RAMP_DEC   (RAMP_DEC)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .wr         (wr[g]),
      .cfg_period (cfg_period),
      .cfg_steps  (cfg_steps),
      .cfg_dir    (cfg_dir),
      .start      (start[g]),
      .abort      (abort[g]),
      .step       (step[g]),
      .dir        (dir[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

endmodule

// File: tb/tb_sm_step_gen.sv
// tb/tb_sm_step_gen.sv - scoreboard bench for sm_step_gen with behavioural reference model
module tb_sm_step_gen;

  localparam int DS  = 2;
  localparam int RD  = 4;
  localparam int PMAX = 65535;

  logic        clk;
  logic        rst;
  logic        cfg_wr;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic [23:0] cfg_steps;
  logic        cfg_dir;
  logic [1:0]  start;
  logic [1:0]  abort;
  logic [1:0]  step;
  logic [1:0]  dir;
  logic [1:0]  busy;
  logic [1:0]  done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] step;
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] dir;
  } exp_t;

  exp_t exp_q[$];

  sm_step_gen dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_steps  (cfg_steps),
    .cfg_dir    (cfg_dir),
    .start      (start),
    .abort      (abort),
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: each channel is "running a pulse train"; position within the
  // current pulse, its length and the pulses still owed are tracked as plain integers.
  initial begin : model
    int   running[2], pos[2], plen[2], owed[2], rdir[2], rdone[2];
    int   sh_p[2], sh_s[2], sh_d[2];
    int   want_p, tgt, want_s, want_d, hi_len;
    bit   sel;
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      running[c] = 0; pos[c] = 0; plen[c] = 2; owed[c] = 0; rdir[c] = 0; rdone[c] = 0;
      sh_p[c] = 0; sh_s[c] = 0; sh_d[c] = 0;
    end
    forever begin
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          running[c] = 0; pos[c] = 0; owed[c] = 0; rdir[c] = 0; rdone[c] = 0;
          sh_p[c] = 0; sh_s[c] = 0; sh_d[c] = 0;
        end else begin
          sel    = cfg_wr && (int'(cfg_ch) == c);
          want_p = sel ? int'(cfg_period) : sh_p[c];
          want_s = sel ? int'(cfg_steps)  : sh_s[c];
          want_d = sel ? int'(cfg_dir)    : sh_d[c];
          tgt    = (want_p < 2) ? 2 : want_p;
          rdone[c] = 0;
          if (running[c] == 0) begin
            if (start[c] && !abort[c]) begin
              if (want_s == 0) rdone[c] = 1;
              else begin
                running[c] = 1; pos[c] = 0; owed[c] = want_s; rdir[c] = want_d;
`ifdef SM_RAMP_EN
                plen[c] = (2 * tgt > PMAX) ? PMAX : 2 * tgt;
`else
                plen[c] = tgt;
`endif
              end
            end
          end else if (abort[c]) begin
            running[c] = 0;
          end else if (pos[c] + 1 == plen[c]) begin
            pos[c] = 0;
            owed[c] = owed[c] - 1;
            if (owed[c] == 0) begin
              running[c] = 0;
              rdone[c] = 1;
            end else begin
`ifdef SM_RAMP_EN
              plen[c] = (plen[c] - RD > tgt) ? plen[c] - RD : tgt;
`else
              plen[c] = tgt;
`endif
            end
          end else begin
            pos[c] = pos[c] + 1;
          end
          if (sel) begin
            sh_p[c] = int'(cfg_period); sh_s[c] = int'(cfg_steps); sh_d[c] = int'(cfg_dir);
          end
        end
        hi_len = plen[c] >> DS;
        if (hi_len < 1) hi_len = 1;
        e.busy[c] = (running[c] != 0);
        e.step[c] = (running[c] != 0) && (pos[c] < hi_len);
        e.done[c] = (rdone[c] != 0);
        e.dir[c]  = rdir[c][0];
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: pops one expected record per cycle and compares it on the falling edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int c = 0; c < 2; c++) begin
          n_cmp++;
          if (step[c] !== e.step[c] || busy[c] !== e.busy[c] || done[c] !== e.done[c] ||
              (e.busy[c] && dir[c] !== e.dir[c])) begin
            n_bad++;
            $display("FAIL cycle_ch%0d t=%0t step/busy/done/dir got %b%b%b%b want %b%b%b%b",
                     c, $time, step[c], busy[c], done[c], dir[c],
                     e.step[c], e.busy[c], e.done[c], e.dir[c]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int c, input int p, input int s, input int d);
    cfg_wr     = 1'b1;
    cfg_ch     = 1'(c);
    cfg_period = 16'(p);
    cfg_steps  = 24'(s);
    cfg_dir    = 1'(d);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    start = m;
    tick();
    start = 2'b00;
  endtask

  // Count busy and step-high cycles of one run; report done seen as busy falls
  task automatic measure(input int c, output int nbusy, output int nhigh, output int dn);
    bit fin;
    nbusy = 0; nhigh = 0; dn = 0; fin = 0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      if (busy[c]) begin
        nbusy++;
        if (step[c]) nhigh++;
      end else begin
        dn  = int'(done[c]);
        fin = 1;
      end
    end
    if (!fin) chk("run_timeout", 0, 1);
  endtask

  initial begin : stim
    int nb, nh, dn, nb1, nh1, dn1;
    rst = 1'b1; cfg_wr = 1'b0; cfg_ch = 1'b0; cfg_period = '0; cfg_steps = '0;
    cfg_dir = 1'b0; start = 2'b00; abort = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    repeat (100) tick();

    pulse_start(2'b01);
    measure(0, nb, nh, dn);
    chk("zero_steps_busy", nb, 0);
    chk("zero_steps_done", dn, 1);
    repeat (3) tick();

    write_cfg(0, 8, 3, 1);
    pulse_start(2'b01);
    measure(0, nb, nh, dn);
`ifdef SM_RAMP_EN
    chk("p8_busy", nb, 36);
    chk("p8_high", nh, 9);
`else
    chk("p8_busy", nb, 24);
    chk("p8_high", nh, 6);
`endif
    chk("p8_done", dn, 1);
    repeat (3) tick();

    cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_period = 16'd1; cfg_steps = 24'd4; cfg_dir = 1'b0;
    start = 2'b01;
    tick();
    cfg_wr = 1'b0; start = 2'b00;
    measure(0, nb, nh, dn);
`ifdef SM_RAMP_EN
    chk("clamp_busy", nb, 10);
`else
    chk("clamp_busy", nb, 8);
`endif
    chk("clamp_high", nh, 4);
    chk("clamp_done", dn, 1);
    repeat (3) tick();

    write_cfg(0, 8, 3, 1);
    pulse_start(2'b01);
    fork
      measure(0, nb, nh, dn);
      begin
        tick();
        write_cfg(0, 16, 3, 1);
      end
    join
`ifdef SM_RAMP_EN
    chk("midrun_busy", nb, 48);
    chk("midrun_high", nh, 12);
`else
    chk("midrun_busy", nb, 40);
    chk("midrun_high", nh, 10);
`endif
    repeat (3) tick();

    write_cfg(0, 10, 5, 0);
    write_cfg(1, 6, 10, 1);
    pulse_start(2'b11);
    fork
      measure(0, nb, nh, dn);
      measure(1, nb1, nh1, dn1);
      begin
        repeat (4) tick();
        abort = 2'b10;
        tick();
        abort = 2'b00;
      end
    join
    chk("abort_ch1_busy", nb1, 5);
    chk("abort_ch1_nodone", dn1, 0);
`ifdef SM_RAMP_EN
    chk("abort_ch0_busy", nb, 68);
    chk("abort_ch0_high", nh, 16);
`else
    chk("abort_ch0_busy", nb, 50);
    chk("abort_ch0_high", nh, 10);
`endif
    chk("abort_ch0_done", dn, 1);
    repeat (3) tick();

`ifdef SM_RAMP_EN
    write_cfg(0, 20, 8, 1);
    pulse_start(2'b01);
    measure(0, nb, nh, dn);
    chk("ramp_busy", nb, 220);
    chk("ramp_high", nh, 55);
    repeat (3) tick();
`endif

    for (int k = 0; k < 4000; k++) begin
      rst        = ($urandom_range(0, 599) == 0);
      cfg_wr     = ($urandom_range(0, 3) == 0);
      cfg_ch     = 1'($urandom_range(0, 1));
      cfg_period = 16'($urandom_range(0, 12));
      cfg_steps  = 24'($urandom_range(0, 4));
      cfg_dir    = 1'($urandom_range(0, 1));
      start      = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      abort      = {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)};
      tick();
    end
    rst = 1'b0; cfg_wr = 1'b0; start = 2'b00; abort = 2'b00;
    repeat (200) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sm_step_gen.md
# sm_step_gen

Multi-channel stepper-motor step-pulse generator for the SM drive path. Each of NCH channels emits a programmable number of step pulses at a programmable period and duty, with a direction output and busy/done status. It replaces the single-channel, free-running step former: it adds per-channel step counting, glitch-free period updates, abort, and an optional acceleration ramp. Configuration arrives on a shared write bus from the control/ADC sequencer.

## Interface
- NCH, 2: number of independent channels (1..8)
- W, 16: period counter width in clk cycles
- CW, 24: step-count width
- DUTY_SHIFT, 2: high time = period >> DUTY_SHIFT (min 1 cycle)
- RAMP_DEC, 4: period decrement per step when ramp is compiled in
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset rst, synchronous, active-high; clock clk
- cfg_wr  in  1  write strobe for shadow config of channel cfg_ch
- cfg_ch  in  $clog2(NCH) (min 1)  target channel; values >= NCH ignored
- cfg_period  in  W  step period in cycles
- cfg_steps  in  CW  number of steps for next run
- cfg_dir  in  1  direction for next run
- start  in  NCH  per-channel run request
- abort  in  NCH  per-channel stop request
- step  out  NCH  step pulse to driver
- dir  out  NCH  direction to driver, held for whole run
- busy  out  NCH  channel running
- done  out  NCH  1-cycle pulse on normal run completion

## Operation
- Per channel: shadow regs (period, steps, dir) written on cfg_wr; active regs loaded from shadow on start, or from the cfg bus if cfg_wr targets the same channel in the same cycle (bypass).
- Period clamp: effective period = max(cfg_period, 2). hi = max(1, period >> DUTY_SHIFT).
- FSM per channel: IDLE, RUN.
- IDLE: step=0, busy=0. start -> if steps==0: done pulse next cycle, stay IDLE; else RUN, cnt=0, steps_left=steps, dir latched.
- RUN: cnt counts 0..period_act-1 and wraps; step=1 while cnt < hi. At wrap: steps_left -= 1; if it reaches 0 -> IDLE with done=1 for one cycle; otherwise continue.
- Shadow period written during RUN is adopted only at the next wrap (never mid-pulse). Shadow steps/dir affect only the next run.
- start while busy: ignored. abort: -> IDLE next cycle, step=0, no done; abort wins over simultaneous start.
- Counter arithmetic in W bits, steps_left in CW bits, no wrap possible (clamped/terminated before).

## Timing
- Reset values: step=0, dir=0, busy=0, done=0, all shadows 0, FSM IDLE.
- start at edge t -> busy, dir, step all 1 from t+1 (zero extra latency).
- Run of N steps at period P: busy high exactly N*P cycles; done asserted in the cycle busy falls.
- rst mid-run: all outputs return to reset values next edge; no done.
- Channels fully independent; simultaneous events on different channels do not interact.

## Configuration
- SM_RAMP_EN defined: on start, period_act = min(2^W-1, 2*target); at each wrap, period_act = max(target, period_act - RAMP_DEC). A larger new target is adopted directly at the next wrap; a smaller one is approached by the ramp. hi is recomputed from period_act.
- Undefined: period_act = target from the first pulse; no ramp logic synthesised.

## Structure
- Package sm_step_pkg: state enum (IDLE, RUN), MIN_PERIOD=2 constant, function for hi width.
- Sub-module sm_step_chan: one channel (shadow, active, FSM, counters), generated NCH times; top holds cfg decode only.

## Test plan
- Reset then idle: all outputs 0 for 100 cycles, start with steps=0 on ch0 -> done pulse at t+1, step never rises.
- ch0 period=8, steps=3, DUTY_SHIFT=2: step high 2 cycles every 8; busy 24 cycles; done at cycle 24 after start.
- cfg_period 1 -> clamped to 2, hi=1: alternating step 1/0 pattern.
- Mid-run write period 8 -> 16 during pulse: current period completes at 8, next at 16; no truncated pulse.
- abort ch1 at cycle 5 of run while ch0 runs: ch1 step=0, busy=0 next cycle, no done; ch0 unaffected.
- SM_RAMP_EN, target 20, RAMP_DEC 4: periods 40,36,32,28,24,20,20...
